// File: rtl/ptmch_cmd_cnt_if.sv
// Byte-stream bundle from the SPI bus monitor into the command counter.
// The monitor drives it (master); the counter stage observes it (slave).
interface ptmch_cmd_cnt_if;
  logic       FRAME_START;
  logic       FRAME_END;
  logic       BYTE_VALID;
  logic [7:0] BYTE_DATA;

  modport master (output FRAME_START, FRAME_END, BYTE_VALID, BYTE_DATA);
  modport slave  (input  FRAME_START, FRAME_END, BYTE_VALID, BYTE_DATA);
endinterface

// File: rtl/ptmch_cmd_cnt.sv
// SPI NAND command snooper: parses opcode + address bytes of each frame,
// tests the address against a per-command inclusive window and keeps four
// saturating 32-bit event counters with a one-cycle increment strobe.
module ptmch_cmd_cnt (
  input  logic                CLK100M,
  input  logic                RESET,
  ptmch_cmd_cnt_if.slave      mon,
  input  logic                CNT_CLR,
  input  logic [23:0]         PRGEXCT_LOW_ADDR,
  input  logic [23:0]         PRGEXCT_HIGH_ADDR,
  input  logic [23:0]         RDSTAT_LOW_ADDR,
  input  logic [23:0]         RDSTAT_HIGH_ADDR,
  input  logic [23:0]         BLKERS_LOW_ADDR,
  input  logic [23:0]         BLKERS_HIGH_ADDR,
  input  logic [23:0]         PDREAD_LOW_ADDR,
  input  logic [23:0]         PDREAD_HIGH_ADDR,
  output logic [31:0]         PRGEXCT,
  output logic [31:0]         RDSTAT,
  output logic [31:0]         BLKERS,
  output logic [31:0]         PDREAD,
  output logic [3:0]          CNT_EVENT
);

  localparam logic [7:0] P_OP_PRGEXCT = 8'h10;
  localparam logic [7:0] P_OP_RDSTAT  = 8'h0F;
  localparam logic [7:0] P_OP_BLKERS  = 8'hD8;
  localparam logic [7:0] P_OP_PDREAD  = 8'h13;

  // Opcode per counter slot, slot 0 in the low byte: {PDREAD, BLKERS, RDSTAT, PRGEXCT}
  localparam logic [31:0] OPC_TABLE = {P_OP_PDREAD, P_OP_BLKERS, P_OP_RDSTAT, P_OP_PRGEXCT};

  typedef enum logic [2:0] {IDLE, OPC, ADDR, EVAL, CMT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  opcode_reg, opcode_next;
  logic [7:0]  b1_reg, b1_next;        // first address byte, kept for the RDSTAT form
  logic [23:0] addr_reg, addr_next;    // bytes 1..3, MSB first
  logic [1:0]  bcnt_reg, bcnt_next;    // address bytes seen, saturating at 3
  logic        pend_reg, pend_next;    // FRAME_START seen while evaluating
  logic [3:0]  hit_reg, hit_next;
  logic [3:0]  event_reg, event_next;

  logic [3:0]  hit_vec;
  logic [23:0] low_w  [4];
  logic [23:0] high_w [4];

  assign low_w[0]  = PRGEXCT_LOW_ADDR;
  assign high_w[0] = PRGEXCT_HIGH_ADDR;
  assign low_w[1]  = RDSTAT_LOW_ADDR;
  assign high_w[1] = RDSTAT_HIGH_ADDR;
  assign low_w[2]  = BLKERS_LOW_ADDR;
  assign high_w[2] = BLKERS_HIGH_ADDR;
  assign low_w[3]  = PDREAD_LOW_ADDR;
  assign high_w[3] = PDREAD_HIGH_ADDR;

  // Per-command qualification and window test; only consumed in EVAL.
  // An inverted window (LOW > HIGH) can never satisfy both compares.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hit
      localparam logic [7:0] OP    = OPC_TABLE[gi*8 +: 8];
      localparam bit         IS_RD = (gi == 1);
      logic [23:0] eval_addr;
      logic        qual;
      assign eval_addr   = IS_RD ? {16'h0, b1_reg} : addr_reg;
      assign qual        = IS_RD ? (bcnt_reg != 2'd0) : (bcnt_reg == 2'd3);
      assign hit_vec[gi] = (opcode_reg == OP) && qual &&
                           (low_w[gi] <= eval_addr) && (eval_addr <= high_w[gi]);
    end
  endgenerate

  // Frame parser state register
  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      state_reg  <= IDLE;
      opcode_reg <= 8'h0;
      b1_reg     <= 8'h0;
      addr_reg   <= 24'h0;
      bcnt_reg   <= 2'd0;
      pend_reg   <= 1'b0;
      hit_reg    <= 4'h0;
      event_reg  <= 4'h0;
    end else begin
      state_reg  <= state_next;
      opcode_reg <= opcode_next;
      b1_reg     <= b1_next;
      addr_reg   <= addr_next;
      bcnt_reg   <= bcnt_next;
      pend_reg   <= pend_next;
      hit_reg    <= hit_next;
      event_reg  <= event_next;
    end
  end

  // Next-state: restart on FRAME_START while parsing, defer it while evaluating
  always_comb begin
    state_next  = state_reg;
    opcode_next = opcode_reg;
    b1_next     = b1_reg;
    addr_next   = addr_reg;
    bcnt_next   = bcnt_reg;
    pend_next   = pend_reg;
    hit_next    = hit_reg;
    event_next  = 4'h0;
    case (state_reg)
      IDLE: begin
        if (mon.FRAME_START) state_next = OPC;
      end
      OPC: begin
        if (mon.FRAME_START) begin
          state_next = OPC;
        end else if (mon.FRAME_END) begin
          state_next = IDLE;
        end else if (mon.BYTE_VALID) begin
          opcode_next = mon.BYTE_DATA;
          b1_next     = 8'h0;
          addr_next   = 24'h0;
          bcnt_next   = 2'd0;
          state_next  = ADDR;
        end
      end
      ADDR: begin
        if (mon.FRAME_START) begin
          state_next = OPC;
        end else if (mon.FRAME_END) begin
          state_next = EVAL;
        end else if (mon.BYTE_VALID && (bcnt_reg != 2'd3)) begin
          addr_next = {addr_reg[15:0], mon.BYTE_DATA};
          if (bcnt_reg == 2'd0) b1_next = mon.BYTE_DATA;
          bcnt_next = bcnt_reg + 2'd1;
        end
      end
      EVAL: begin
        hit_next   = hit_vec;
        pend_next  = pend_reg | mon.FRAME_START;
        state_next = CMT;
      end
      CMT: begin
        event_next = hit_reg;
        pend_next  = 1'b0;
        state_next = (pend_reg || mon.FRAME_START) ? OPC : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Saturating event counters; a clear overrides a coincident increment
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [31:0] cnt_reg, cnt_next;

      // Counter next value
      always_comb begin
        cnt_next = cnt_reg;
        if (CNT_CLR) begin
          cnt_next = 32'h0;
        end else if ((state_reg == CMT) && hit_reg[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      // Counter register
      always_ff @(posedge CLK100M) begin
        if (RESET) cnt_reg <= 32'h0;
        else       cnt_reg <= cnt_next;
      end
    end
  endgenerate

  assign PRGEXCT   = g_cnt[0].cnt_reg;
  assign RDSTAT    = g_cnt[1].cnt_reg;
  assign BLKERS    = g_cnt[2].cnt_reg;
  assign PDREAD    = g_cnt[3].cnt_reg;
  assign CNT_EVENT = event_reg;

endmodule

// File: tb/tb_ptmch_cmd_cnt.sv
// Testbench for ptmch_cmd_cnt: directed frames, expected strobes/counter
// snapshots queued at FRAME_END and checked by an independent monitor.
module tb_ptmch_cmd_cnt;

  logic        CLK100M = 1'b0;
  logic        RESET   = 1'b1;
  logic        CNT_CLR = 1'b0;
  logic [23:0] PRGEXCT_LOW_ADDR = 24'h0, PRGEXCT_HIGH_ADDR = 24'hFFFFFF;
  logic [23:0] RDSTAT_LOW_ADDR  = 24'h0, RDSTAT_HIGH_ADDR  = 24'hFFFFFF;
  logic [23:0] BLKERS_LOW_ADDR  = 24'h0, BLKERS_HIGH_ADDR  = 24'hFFFFFF;
  logic [23:0] PDREAD_LOW_ADDR  = 24'h0, PDREAD_HIGH_ADDR  = 24'hFFFFFF;
  logic [31:0] PRGEXCT, RDSTAT, BLKERS, PDREAD;
  logic [3:0]  CNT_EVENT;

  ptmch_cmd_cnt_if bus ();

  ptmch_cmd_cnt dut (
    .CLK100M          (CLK100M),
    .RESET            (RESET),
    .mon              (bus),
    .CNT_CLR          (CNT_CLR),
    .PRGEXCT_LOW_ADDR (PRGEXCT_LOW_ADDR),
    .PRGEXCT_HIGH_ADDR(PRGEXCT_HIGH_ADDR),
    .RDSTAT_LOW_ADDR  (RDSTAT_LOW_ADDR),
    .RDSTAT_HIGH_ADDR (RDSTAT_HIGH_ADDR),
    .BLKERS_LOW_ADDR  (BLKERS_LOW_ADDR),
    .BLKERS_HIGH_ADDR (BLKERS_HIGH_ADDR),
    .PDREAD_LOW_ADDR  (PDREAD_LOW_ADDR),
    .PDREAD_HIGH_ADDR (PDREAD_HIGH_ADDR),
    .PRGEXCT          (PRGEXCT),
    .RDSTAT           (RDSTAT),
    .BLKERS           (BLKERS),
    .PDREAD           (PDREAD),
    .CNT_EVENT        (CNT_EVENT)
  );

  always #5 CLK100M = ~CLK100M;

  int cyc = 0;
  always @(posedge CLK100M) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  ev;
    logic [31:0] c0, c1, c2, c3;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] exp_cnt [4];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge CLK100M) begin
    if (!RESET) begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_event: no strobe at cycle %0d, expected ev %b", sbq[0].cyc, sbq[0].ev);
        void'(sbq.pop_front());
      end
      if (CNT_EVENT != 4'h0) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got %b at cycle %0d, expected none", CNT_EVENT, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("event_bits", {28'h0, CNT_EVENT}, {28'h0, e.ev});
          chk("event_cycle", cyc, e.cyc);
          chk("ev_prgexct", PRGEXCT, e.c0);
          chk("ev_rdstat",  RDSTAT,  e.c1);
          chk("ev_blkers",  BLKERS,  e.c2);
          chk("ev_pdread",  PDREAD,  e.c3);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK100M);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start();
    tick();
    bus.FRAME_START = 1'b1;
    tick();
    bus.FRAME_START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    bus.BYTE_VALID = 1'b1;
    bus.BYTE_DATA  = b;
    tick();
    bus.BYTE_VALID = 1'b0;
  endtask

  // Pulse FRAME_END and queue the expected strobe two edges after it is sampled
  task automatic end_frame(input logic [3:0] ev, input bit clr, input bit start_next);
    exp_t e;
    tick();
    bus.FRAME_END = 1'b1;
    if (ev != 4'h0) begin
      for (int i = 0; i < 4; i++)
        if (ev[i] && exp_cnt[i] != 32'hFFFF_FFFF) exp_cnt[i] = exp_cnt[i] + 32'd1;
      if (clr)
        for (int i = 0; i < 4; i++) exp_cnt[i] = 32'h0;
      e.ev  = ev;
      e.c0  = exp_cnt[0];
      e.c1  = exp_cnt[1];
      e.c2  = exp_cnt[2];
      e.c3  = exp_cnt[3];
      e.cyc = cyc + 3;
      sbq.push_back(e);
    end
    tick();
    bus.FRAME_END   = 1'b0;
    bus.FRAME_START = start_next;
    tick();
    bus.FRAME_START = 1'b0;
    CNT_CLR         = clr;
    if (clr) begin
      tick();
      CNT_CLR = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] bytes, input int n, input logic [3:0] ev, input bit clr);
    start();
    for (int i = 0; i < n; i++) send_byte(bytes[31-8*i -: 8]);
    end_frame(ev, clr, 1'b0);
  endtask

  task automatic check_all(input string tag);
    idle(4);
    @(negedge CLK100M);
    chk({tag, "_prgexct"}, PRGEXCT, exp_cnt[0]);
    chk({tag, "_rdstat"},  RDSTAT,  exp_cnt[1]);
    chk({tag, "_blkers"},  BLKERS,  exp_cnt[2]);
    chk({tag, "_pdread"},  PDREAD,  exp_cnt[3]);
    chk({tag, "_event"},   {28'h0, CNT_EVENT}, 32'h0);
  endtask

  initial begin
    bus.FRAME_START = 1'b0;
    bus.FRAME_END   = 1'b0;
    bus.BYTE_VALID  = 1'b0;
    bus.BYTE_DATA   = 8'h0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 32'h0;
    idle(3);
    RESET = 1'b0;
    check_all("reset");

    // Basic Program Execute hit
    frame(32'h10001234, 4, 4'b0001, 1'b0);
    check_all("prg1");

    // PDREAD window boundaries
    PDREAD_LOW_ADDR  = 24'h001000;
    PDREAD_HIGH_ADDR = 24'h001FFF;
    frame(32'h13001000, 4, 4'b1000, 1'b0);
    frame(32'h13001FFF, 4, 4'b1000, 1'b0);
    frame(32'h13002000, 4, 4'b0000, 1'b0);
    frame(32'h13000FFF, 4, 4'b0000, 1'b0);
    check_all("pdwin");

    // RDSTAT single-byte address with trailing status bytes, short frames
    RDSTAT_LOW_ADDR  = 24'h0000C0;
    RDSTAT_HIGH_ADDR = 24'h0000C0;
    frame(32'h0FC0AA55, 4, 4'b0010, 1'b0);
    frame(32'h0F000000, 1, 4'b0000, 1'b0);
    frame(32'hD8000100, 3, 4'b0000, 1'b0);
    check_all("rdst");

    // Inverted window never counts
    PRGEXCT_LOW_ADDR  = 24'h000010;
    PRGEXCT_HIGH_ADDR = 24'h000005;
    frame(32'h10000007, 4, 4'b0000, 1'b0);
    check_all("invwin");
    PRGEXCT_LOW_ADDR  = 24'h0;
    PRGEXCT_HIGH_ADDR = 24'hFFFFFF;

    // Saturation and clear-over-increment
    force dut.g_cnt[2].cnt_reg = 32'hFFFF_FFFE;
    tick();
    release dut.g_cnt[2].cnt_reg;
    exp_cnt[2] = 32'hFFFF_FFFE;
    check_all("preload");
    frame(32'hD8000000, 4, 4'b0100, 1'b0);
    frame(32'hD8000000, 4, 4'b0100, 1'b0);
    check_all("sat");
    frame(32'hD8000000, 4, 4'b0100, 1'b1);
    check_all("clr");

    // FRAME_START mid-address restarts parsing
    PDREAD_LOW_ADDR  = 24'h0;
    PDREAD_HIGH_ADDR = 24'hFFFFFF;
    start();
    send_byte(8'h10);
    send_byte(8'h00);
    frame(32'h13000005, 4, 4'b1000, 1'b0);
    check_all("restart");

    // FRAME_START one cycle after FRAME_END is held pending
    start();
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    end_frame(4'b0001, 1'b0, 1'b1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    end_frame(4'b1000, 1'b0, 1'b0);
    check_all("b2b");

    // RESET mid-address
    start();
    send_byte(8'h10);
    send_byte(8'h00);
    tick();
    RESET = 1'b1;
    idle(2);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 32'h0;
    check_all("rstmid");
    frame(32'h13000003, 4, 4'b1000, 1'b0);
    check_all("postrst");

    idle(5);
    chk("queue_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ptmch_cmd_cnt.md
# ptmch_cmd_cnt

Command-snooping counter stage that feeds the pattern-match register block. It parses SPI NAND command frames delivered by the SPI bus monitor as a byte stream. It extracts the opcode and the 24-bit page/status address, and compares that address against the per-command LOW/HIGH window programmed in the register block. It maintains the four saturating 32-bit event counters that the register block exposes as read-only registers.

## Interface
- P_OP_PRGEXCT, 8'h10, Program Execute opcode
- P_OP_RDSTAT, 8'h0F, Read Status Register opcode
- P_OP_BLKERS, 8'hD8, 128KB Block Erase opcode
- P_OP_PDREAD, 8'h13, Page Data Read opcode
- CLK100M  in  1  system clock, 100 MHz; single clock domain
- RESET  in  1  synchronous, active-high reset
- FRAME_START  in  1  one-cycle pulse at CS_N fall; at least 1 cycle before the first BYTE_VALID
- FRAME_END  in  1  one-cycle pulse at CS_N rise; at least 1 cycle after the last BYTE_VALID
- BYTE_VALID  in  1  BYTE_DATA qualifier, one cycle per MOSI byte
- BYTE_DATA  in  8  MOSI byte, in bus order
- CNT_CLR  in  1  synchronous clear of all four counters
- PRGEXCT_LOW_ADDR / PRGEXCT_HIGH_ADDR  in  24 each  inclusive window, Program Execute
- RDSTAT_LOW_ADDR / RDSTAT_HIGH_ADDR  in  24 each  inclusive window, Read Status
- BLKERS_LOW_ADDR / BLKERS_HIGH_ADDR  in  24 each  inclusive window, Block Erase
- PDREAD_LOW_ADDR / PDREAD_HIGH_ADDR  in  24 each  inclusive window, Page Data Read
- PRGEXCT, RDSTAT, BLKERS, PDREAD  out  32 each  event counters
- CNT_EVENT  out  4  one-cycle increment strobe per counter; bit order {PDREAD, BLKERS, RDSTAT, PRGEXCT}

## Operation
- States:
  - IDLE: wait for FRAME_START, then go to OPC.
  - OPC: first BYTE_VALID latches the opcode and goes to ADDR; FRAME_END goes to IDLE with no count.
  - ADDR: each BYTE_VALID increments a byte counter that saturates at 3. Bytes 1–3 shift into addr[23:0], MSB first. Bytes beyond the 3rd are ignored. FRAME_END goes to EVAL.
  - EVAL: selects the window by opcode, computes hit, registers a 4-bit hit vector, then goes to CMT.
  - CMT: applies increments, pulses CNT_EVENT, then goes to IDLE, or to OPC if a start is pending.
- Qualification in EVAL:
  - PRGEXCT/BLKERS/PDREAD opcodes: require ≥3 address bytes; address = {b1,b2,b3}.
  - RDSTAT: requires ≥1 address byte; address = {16'h0,b1}. Trailing status bytes are permitted.
  - Any other opcode, or too few bytes: hit vector = 0.
- Window test: LOW ≤ addr ≤ HIGH, unsigned, inclusive. If LOW > HIGH, nothing counts. LOW/HIGH are sampled in the EVAL cycle only.
- Counters saturate at 32'hFFFF_FFFF; an increment at saturation still pulses CNT_EVENT.
- CNT_CLR: all counters go to 0 on the next edge. CNT_CLR wins over a coincident CMT increment; CNT_EVENT still pulses.
- FRAME_START in OPC or ADDR: current frame is discarded and parsing restarts in OPC.
- FRAME_START in EVAL or CMT: held in a pending flag; the current evaluation completes, then OPC is entered.
- FRAME_END in IDLE is ignored. BYTE_VALID in IDLE, EVAL or CMT is ignored.
- RESET mid-frame: state goes to IDLE, pending flag cleared, partial frame discarded, counters 0.

## Timing
- Reset values: PRGEXCT = RDSTAT = BLKERS = PDREAD = 32'h0; CNT_EVENT = 4'h0; state IDLE.
- Reference edge E = the edge sampling FRAME_END.
  - E+1: EVAL registers the hit vector.
  - E+2: counter updated and CNT_EVENT high for exactly that one cycle.
- Minimum frame-to-frame spacing is 3 cycles from FRAME_END to the next FRAME_START. Shorter spacing is covered by the pending flag.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Reset, then all windows at default 0..FFFFFF; frame 10 00 12 34 → PRGEXCT = 1 two edges after FRAME_END, CNT_EVENT = 4'b0001 for one cycle, other counters 0.
- PDREAD window 001000..001FFF; frames 13 00 10 00, 13 00 1F FF, 13 00 20 00, 13 00 0F FF → PDREAD = 2 (both boundaries hit, both outside miss).
- Frame 0F C0 xx xx with RDSTAT window 0000C0..0000C0 → RDSTAT = 1; frame 0F alone → no count; frame D8 00 01 (short) → BLKERS unchanged.
- BLKERS preloaded to FFFF_FFFE via repeated frames (forced) → two more D8 frames: FFFF_FFFF, then stays FFFF_FFFF, CNT_EVENT[2] pulses both times; CNT_CLR coincident with a CMT → counter reads 0.
- FRAME_START mid-ADDR after 10 00 → restart, following 13 00 00 05 counts PDREAD only; FRAME_START one cycle after FRAME_END → both frames counted; RESET asserted mid-ADDR → all counters 0, next full frame counts normally.
